bram_capture_ctrl: RTL and testbench

Capture/read-out controller sitting directly upstream of the 32-bit filter-data block RAM. It takes the filter's sample stream, decimates it, and writes a contiguous record into the RAM starting at address 0 until the RAM is full or capture is stopped. It then services random-access read requests from the host side, driving the RAM read port and returning the RAM's one-cycle-latency data with a valid strobe.

---
 rtl/bram_capture_ctrl.sv | 103 ++++++++++
 tb/tb_bram_capture_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bram_capture_ctrl.sv
// bram_capture_ctrl: decimating capture of a sample stream into block RAM,
// followed by pipelined, bounds-checked random-access read-out.
module bram_capture_ctrl #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32000,
    parameter int ADDR_W  = 16,
    parameter int DECIM_W = 8
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [DECIM_W-1:0] i_decim,
    input  logic               i_sample_valid,
    input  logic [WIDTH-1:0]   i_sample,
    input  logic               i_rd_req,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output logic               o_wr_en,
    output logic [ADDR_W-1:0]  o_wr_addr,
    output logic [WIDTH-1:0]   o_wr_data,
    output logic               o_rd_en,
    output logic [ADDR_W-1:0]  o_rd_addr,
    input  logic [WIDTH-1:0]   i_ram_data,
    output logic               o_rd_valid,
    output logic [WIDTH-1:0]   o_rd_data,
    output logic               o_rd_err,
    output logic [ADDR_W:0]    o_count,
    output logic               o_busy,
    output logic               o_full
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
    localparam logic [ADDR_W:0] L_DEPTH = DEPTH[ADDR_W:0];
    state_t               r_state;
    logic [DECIM_W-1:0]   r_decim;
    logic [DECIM_W-1:0]   r_dcnt;
    logic                 r_p1_valid, r_p1_err, r_p2_valid, r_p2_err;
    logic                 w_cap;
    logic                 w_rd_ok;
    logic [ADDR_W:0]      w_count_nxt;
    assign w_cap       = r_state == CAPTURE;
    assign w_rd_ok     = !w_cap && ({1'b0, i_rd_addr} < o_count);
    assign w_count_nxt = o_count + 1'b1;
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_decim    <= '0;
            r_dcnt     <= '0;
            r_p1_valid <= 1'b0;
            r_p1_err   <= 1'b0;
            r_p2_valid <= 1'b0;
            r_p2_err   <= 1'b0;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_rd_en    <= 1'b0;
            o_rd_addr  <= '0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
            o_rd_err   <= 1'b0;
            o_count    <= '0;
            o_busy     <= 1'b0;
            o_full     <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            if (i_start) begin
                r_state <= CAPTURE;
                r_dcnt  <= '0;
                r_decim <= (i_decim == '0) ? DECIM_W'(1) : i_decim;
                o_count <= '0;
                o_full  <= 1'b0;
                o_busy  <= 1'b1;
            end else if (w_cap) begin
                if (i_stop) begin
                    r_state <= DONE;
                    o_busy  <= 1'b0;
                end else if (i_sample_valid) begin
                    r_dcnt <= (r_dcnt == r_decim - 1'b1) ? '0 : r_dcnt + 1'b1;
                    if (r_dcnt == '0) begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= o_count[ADDR_W-1:0];
                        o_wr_data <= i_sample;
                        o_count   <= w_count_nxt;
                        if (w_count_nxt == L_DEPTH) begin
                            r_state <= DONE;
                            o_busy  <= 1'b0;
                            o_full  <= 1'b1;
                        end
                    end
                end
            end
            // Two tag stages line up with the RAM's registered output; errors ride along to keep order.
            o_rd_en    <= i_rd_req && w_rd_ok;
            o_rd_addr  <= (i_rd_req && w_rd_ok) ? i_rd_addr : '0;
            r_p1_valid <= i_rd_req;
            r_p1_err   <= !w_rd_ok;
            r_p2_valid <= r_p1_valid;
            r_p2_err   <= r_p1_err;
            o_rd_valid <= r_p2_valid;
            o_rd_err   <= r_p2_valid && r_p2_err;
            o_rd_data  <= (r_p2_valid && !r_p2_err) ? i_ram_data : '0;
        end
    end
endmodule

// File: tb/tb_bram_capture_ctrl.sv
// tb_bram_capture_ctrl: directed stimulus with a queue scoreboard checked by an
// independent monitor against a behavioural one-cycle-latency RAM.
module tb_bram_capture_ctrl;
    logic        clock = 1'b0;
    logic        i_reset, i_start, i_stop, i_sample_valid, i_rd_req;
    logic [7:0]  i_decim;
    logic [31:0] i_sample, i_ram_data, o_wr_data, o_rd_data;
    logic [15:0] i_rd_addr, o_wr_addr, o_rd_addr;
    logic [16:0] o_count;
    logic        o_wr_en, o_rd_en, o_rd_valid, o_rd_err, o_busy, o_full;

    bram_capture_ctrl #(.WIDTH(32), .DEPTH(8), .ADDR_W(16), .DECIM_W(8)) dut (
        .clock(clock), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
        .i_decim(i_decim), .i_sample_valid(i_sample_valid), .i_sample(i_sample),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_wr_en(o_wr_en),
        .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_rd_en(o_rd_en),
        .o_rd_addr(o_rd_addr), .i_ram_data(i_ram_data), .o_rd_valid(o_rd_valid),
        .o_rd_data(o_rd_data), .o_rd_err(o_rd_err), .o_count(o_count),
        .o_busy(o_busy), .o_full(o_full));

    always #5 clock = ~clock;

    logic [31:0] mem [0:255];
    always @(posedge clock) begin
        if (o_wr_en) mem[o_wr_addr[7:0]] <= o_wr_data;
        if (o_rd_en) i_ram_data <= mem[o_rd_addr[7:0]];
    end

    typedef struct {logic [15:0] addr; logic [31:0] data; int due;} wexp_t;
    typedef struct {logic err; logic [31:0] data; int due;} rexp_t;
    wexp_t wq[$];
    rexp_t rq[$];
    int cyc = 0, n_pass = 0, n_total = 0, n_rden = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string name, longint act, longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clock) begin
        wexp_t w;
        rexp_t r;
        if (o_rd_en) n_rden++;
        if (o_wr_en) begin
            if (wq.size() == 0) chk("unexpected_wr_en", 1, 0);
            else begin
                w = wq.pop_front();
                chk("wr_addr", o_wr_addr, w.addr);
                chk("wr_data", o_wr_data, w.data);
                chk("wr_latency", cyc, w.due);
            end
        end
        if (o_rd_valid) begin
            if (rq.size() == 0) chk("unexpected_rd_valid", 1, 0);
            else begin
                r = rq.pop_front();
                chk("rd_err", o_rd_err, r.err);
                chk("rd_data", o_rd_data, r.data);
                chk("rd_latency", cyc, r.due);
            end
        end
    end

    task automatic clr();
        i_reset = 0; i_start = 0; i_stop = 0; i_decim = 0;
        i_sample_valid = 0; i_sample = 0; i_rd_req = 0; i_rd_addr = 0;
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(negedge clock);
        clr();
    endtask

    task automatic start(logic [7:0] d);
        i_start = 1; i_decim = d;
        tick();
    endtask

    task automatic sample(logic [31:0] s, logic store, logic [15:0] addr);
        i_sample_valid = 1; i_sample = s;
        if (store) wq.push_back('{addr, s, cyc + 1});
        tick();
    endtask

    task automatic read(logic [15:0] a, logic err, logic [31:0] d);
        i_rd_req = 1; i_rd_addr = a;
        rq.push_back('{err, d, cyc + 3});
        tick();
    endtask

    initial begin
        clr();
        i_reset = 1;
        repeat (2) @(negedge clock);
        clr();
        chk("rst_count", o_count, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_full", o_full, 0);
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_rd_valid", o_rd_valid, 0);
        chk("rst_rd_en", o_rd_en, 0);

        // 5-word record at decim 1
        start(8'd1);
        chk("busy_after_start", o_busy, 1);
        for (int i = 0; i < 5; i++) sample(32'h11 + i, 1, 16'(i));
        i_stop = 1;
        tick();
        chk("rec5_count", o_count, 5);
        chk("rec5_busy", o_busy, 0);
        chk("rec5_full", o_full, 0);
        read(16'd0, 0, 32'h11);
        read(16'd4, 0, 32'h15);
        read(16'd5, 1, 32'h0);
        read(16'd2, 0, 32'h13);
        tick(4);

        // decimate by 3: stores 1,4,7,10
        start(8'd3);
        for (int i = 1; i <= 10; i++) sample(32'(i), (i % 3) == 1, 16'((i - 1) / 3));
        i_stop = 1;
        tick();
        chk("decim3_count", o_count, 4);

        // fill to DEPTH=8 with a read during capture; extra samples must not write
        start(8'd0);
        for (int i = 0; i < 12; i++) begin
            if (i == 2) begin
                i_rd_req = 1; i_rd_addr = 0;
                rq.push_back('{1'b1, 32'h0, cyc + 3});
            end
            sample(32'h100 + i, i < 8, 16'(i));
        end
        chk("full_count", o_count, 8);
        chk("full_flag", o_full, 1);
        chk("full_busy", o_busy, 0);
        read(16'd7, 0, 32'h107);
        read(16'd8, 1, 32'h0);
        tick(4);

        // reset mid-capture with an error read in flight
        start(8'd1);
        for (int i = 0; i < 3; i++) sample(32'h50 + i, 1, 16'(i));
        i_rd_req = 1; i_rd_addr = 0;
        tick();
        i_reset = 1; i_sample_valid = 1; i_sample = 32'hdead;
        tick();
        chk("rstmid_count", o_count, 0);
        chk("rstmid_busy", o_busy, 0);
        chk("rstmid_wr_en", o_wr_en, 0);
        chk("rstmid_rd_valid", o_rd_valid, 0);
        chk("rstmid_rd_en", o_rd_en, 0);
        chk("rstmid_wr_data", o_wr_data, 0);
        tick(3);
        start(8'd1);
        sample(32'hA0, 1, 16'd0);
        sample(32'hA1, 1, 16'd1);
        i_stop = 1;
        tick();
        chk("recap_count", o_count, 2);
        read(16'd1, 0, 32'hA1);
        tick(5);

        chk("wr_queue_drained", wq.size(), 0);
        chk("rd_queue_drained", rq.size(), 0);
        chk("rd_en_pulses", n_rden, 5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
